mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port data/instruction memory (word-indexed, combinational read, synchronous write, 3-bit width code) between two requesters.
- The requesters are the instruction-fetch unit (IF) and the load/store unit (LS).
- Arbitrates in the request cycle, drives the memory port, and returns registered read data one cycle later.
- A starvation guard stops back-to-back LS traffic from locking out fetch indefinitely.

Parameters:
- N, 12, memory index width; only addr[N-1:0] is forwarded, upper bits are driven 0.
- STARVE_LIMIT, 4, consecutive denied IF cycles after which IF wins the next contention; legal range 1..15.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  32  fetch word index
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  if_rdata valid (one cycle after if_gnt)
- if_rdata  out  32  fetched word
- ls_req  in  1  load/store request; held with all ls_* stable until ls_gnt
- ls_we  in  1  1 = store
- ls_addr  in  32  word index
- ls_width  in  3  width code: 000 byte, 001 half, 010 word; bit2 = unsigned load
- ls_wdata  in  32  store data
- ls_gnt  out  1  LS accepted this cycle
- ls_rvalid  out  1  completion strobe, one cycle after ls_gnt (loads and stores)
- ls_rdata  out  32  load data; 0 for stores
- mem_addr  out  32  to memory
- mem_width  out  3  to memory
- mem_we  out  1  to memory
- mem_wdata  out  32  to memory
- mem_rdata  in  32  from memory (combinational)

Behaviour:
- Grant is combinational within the request cycle. At most one of if_gnt/ls_gnt is high in any cycle.
- Throughput is one access per cycle with no bubbles.
- Only LS requesting: ls_gnt=1. Only IF requesting: if_gnt=1. Neither: no grant.
  - Idle port values: mem_we=0, mem_addr=0, mem_width=010, mem_wdata=0.
- Both requesting (contention): LS wins unless starve_cnt == STARVE_LIMIT, in which case IF wins.
- starve_cnt (4-bit register) update:
  - reset to 0;
  - +1 in each cycle with if_req=1 and if_gnt=0, saturating at STARVE_LIMIT;
  - cleared to 0 when if_gnt=1 or if_req=0.
- Granted IF: mem_addr={0,if_addr[N-1:0]}, mem_width=010, mem_we=0.
- Granted LS: mem_addr={0,ls_addr[N-1:0]}, mem_width=ls_width, mem_we=ls_we, mem_wdata=ls_wdata. The store commits at the memory on that clock edge.
- Response registers (rsp_src, rsp_data), loaded on every rising edge:
  - if_rvalid <= if_gnt; ls_rvalid <= ls_gnt;
  - if_rdata <= mem_rdata when if_gnt, else hold;
  - ls_rdata <= mem_rdata when LS load is granted, 0 when LS store is granted, else hold.
- Latency: a read is visible exactly 1 cycle after grant.
- Read-after-write: a store granted in cycle t followed by a read granted in t+1 returns the new data, because memory write-first is on the clock edge.
- Reset asserted, including mid-operation: starve_cnt=0, if_rvalid=0, ls_rvalid=0, if_rdata=0, ls_rdata=0, all asynchronously. A pending response is dropped, not replayed.
  - While i_rst_n=0, grants are forced to 0 and mem_we is forced to 0, so no stray store can occur.
- A requester that drops req before its grant is not an error; its request is simply never serviced.

Optional Feature:
- MEM_PORT_ARBITER_PERF_EN defined:
  - adds output o_conflict_cnt[31:0], counting cycles with if_req=1 and ls_req=1;
  - adds output o_starve_cnt[31:0], counting cycles in which IF won via the starvation guard;
  - both saturate at all-ones and reset to 0.
- Undefined: neither port nor any counter logic exists.

Decomposition:
- Package mem_arb_pkg holds:
  - width constants MEM_W_BYTE=3'b000, MEM_W_HALF=3'b001, MEM_W_WORD=3'b010, MEM_W_UNSIGNED_BIT=2;
  - grant-source enum SRC_NONE/SRC_IF/SRC_LS.
- One sub-module, mem_arb_starve_cnt: the saturating starvation counter and its priority-flip output. All other logic stays inline.

Test Plan:
- IF-only stream: if_req=1 with addr 0,1,2 over 3 cycles, memory preloaded with 0xA0+i. Expect if_gnt=1 every cycle; if_rdata = 0xA0, 0xA1, 0xA2 on the following cycles with if_rvalid=1.
- LS store word 0xDEADBEEF to addr 5, then load byte signed (000) from addr 5. Expect ls_gnt both cycles; ls_rdata 0 for the store; the load returns 0xFFFFFFEF with ls_rvalid=1.
- Contention with STARVE_LIMIT=4: both req held continuously. Expect ls_gnt for 4 cycles, if_gnt in cycle 5, starve_cnt back to 0, then ls_gnt again. The pattern repeats with period 5.
- Simultaneous single request: both req for 1 cycle from idle. Expect ls_gnt=1, if_gnt=0; IF still held is granted next cycle; exactly one rvalid per cycle.
- Reset mid-op: assert i_rst_n=0 the cycle after ls_gnt of a load. Expect ls_rvalid and ls_rdata to go 0 immediately, mem_we=0, and no grant until reset deasserts.
- With MEM_PORT_ARBITER_PERF_EN: 10 contention cycles. Expect o_conflict_cnt=10 and o_starve_cnt=2.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the memory port arbiter.
// Width codes follow the memory's 3-bit encoding; bit 2 marks an unsigned load.
package mem_arb_pkg;

   localparam logic [2:0] MEM_W_BYTE         = 3'b000;
   localparam logic [2:0] MEM_W_HALF         = 3'b001;
   localparam logic [2:0] MEM_W_WORD         = 3'b010;
   localparam int         MEM_W_UNSIGNED_BIT = 2;

   // Which requester owns the memory port in a given cycle.
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_IF   = 2'd1,
      SRC_LS   = 2'd2
   } src_t;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Starvation guard for instruction fetch.
// Counts consecutive cycles in which IF asked but was denied, and raises
// if_prio once the count reaches STARVE_LIMIT so IF wins the next contention.
module mem_arb_starve_cnt #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic if_req,
   input  logic if_gnt,
   output logic if_prio
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_cnt;

   // Saturating denied-cycle count; any grant or idle cycle restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         starve_cnt <= '0;
      else if (!if_req || if_gnt)
         starve_cnt <= '0;
      else if (starve_cnt != LIMIT)
         starve_cnt <= starve_cnt + 4'd1;
   end

   assign if_prio = (starve_cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared single-port memory (IF and LS).
// Grant is combinational in the request cycle; read data is registered and
// returned one cycle after grant. LS has priority except when the starvation
// guard flips it to IF.
// Optional: define MEM_PORT_ARBITER_PERF_EN to add conflict / starvation-win
// performance counters (o_conflict_cnt, o_starve_cnt).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int N            = 12,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [31:0] ls_addr,
   input  logic [2:0]  ls_width,
   input  logic [31:0] ls_wdata,
   output logic        ls_gnt,
   output logic        ls_rvalid,
   output logic [31:0] ls_rdata,
   output logic [31:0] mem_addr,
   output logic [2:0]  mem_width,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
`ifdef MEM_PORT_ARBITER_PERF_EN
   ,
   output logic [31:0] o_conflict_cnt,
   output logic [31:0] o_starve_cnt
`endif
);

   src_t gnt_src;
   src_t rsp_src;
   logic if_prio;

   // Only the low N index bits reach the memory.
   logic unused_addr_hi;
   assign unused_addr_hi = ^{if_addr[31:N], ls_addr[31:N]};

   mem_arb_starve_cnt #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .if_req  (if_req),
      .if_gnt  (if_gnt),
      .if_prio (if_prio)
   );

   // Pick the port owner; no grant at all while reset is held.
   always_comb begin
      gnt_src = SRC_NONE;
      if (i_rst_n) begin
         if (ls_req && !(if_req && if_prio))
            gnt_src = SRC_LS;
         else if (if_req)
            gnt_src = SRC_IF;
      end
   end

   assign if_gnt = (gnt_src == SRC_IF);
   assign ls_gnt = (gnt_src == SRC_LS);

   // Drive the memory port from the winner; idle values otherwise.
   always_comb begin
      mem_addr  = '0;
      mem_width = MEM_W_WORD;
      mem_we    = 1'b0;
      mem_wdata = '0;
      case (gnt_src)
         SRC_IF: mem_addr = 32'(if_addr[N-1:0]);
         SRC_LS: begin
            mem_addr  = 32'(ls_addr[N-1:0]);
            mem_width = ls_width;
            mem_we    = ls_we;
            mem_wdata = ls_wdata;
         end
         default: ;
      endcase
   end

   // Capture the response one cycle after grant; stores return zero data.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rsp_src  <= SRC_NONE;
         if_rdata <= '0;
         ls_rdata <= '0;
      end else begin
         rsp_src <= gnt_src;
         if (gnt_src == SRC_IF)
            if_rdata <= mem_rdata;
         if (gnt_src == SRC_LS)
            ls_rdata <= ls_we ? 32'd0 : mem_rdata;
      end
   end

   assign if_rvalid = (rsp_src == SRC_IF);
   assign ls_rvalid = (rsp_src == SRC_LS);

`ifdef MEM_PORT_ARBITER_PERF_EN
   // Saturating counts of contention cycles and guard-forced IF wins.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_conflict_cnt <= '0;
         o_starve_cnt   <= '0;
      end else begin
         if (if_req && ls_req && (o_conflict_cnt != '1))
            o_conflict_cnt <= o_conflict_cnt + 32'd1;
         if (if_gnt && ls_req && (o_starve_cnt != '1))
            o_starve_cnt <= o_starve_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural memory model
// (combinational read with width/sign extraction, synchronous write).
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_gnt, if_rvalid;
   logic [31:0] if_rdata;
   logic        ls_req = 1'b0, ls_we = 1'b0;
   logic [31:0] ls_addr = '0;
   logic [2:0]  ls_width = MEM_W_WORD;
   logic [31:0] ls_wdata = '0;
   logic        ls_gnt, ls_rvalid;
   logic [31:0] ls_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [2:0]  mem_width;
   logic        mem_we;
`ifdef MEM_PORT_ARBITER_PERF_EN
   logic [31:0] o_conflict_cnt, o_starve_cnt;
`endif

   mem_port_arbiter #(.N(12), .STARVE_LIMIT(4)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_width(ls_width),
      .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_addr(mem_addr), .mem_width(mem_width), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_PORT_ARBITER_PERF_EN
      , .o_conflict_cnt(o_conflict_cnt), .o_starve_cnt(o_starve_cnt)
`endif
   );

   always #5 i_clk = ~i_clk;

   // Memory model
   logic [31:0] tmem [0:4095];
   logic [31:0] rd_word;
   logic        unused_hi;
   assign unused_hi = ^mem_addr[31:12];

   always_comb begin
      rd_word = tmem[mem_addr[11:0]];
      case (mem_width[1:0])
         2'b00:   mem_rdata = mem_width[2] ? {24'h0, rd_word[7:0]} : {{24{rd_word[7]}}, rd_word[7:0]};
         2'b01:   mem_rdata = mem_width[2] ? {16'h0, rd_word[15:0]} : {{16{rd_word[15]}}, rd_word[15:0]};
         default: mem_rdata = rd_word;
      endcase
   end

   always @(posedge i_clk) begin
      if (mem_we) begin
         case (mem_width[1:0])
            2'b00:   tmem[mem_addr[11:0]][7:0]  <= mem_wdata[7:0];
            2'b01:   tmem[mem_addr[11:0]][15:0] <= mem_wdata[15:0];
            default: tmem[mem_addr[11:0]]       <= mem_wdata;
         endcase
      end
   end

   // Scoreboard
   int checks = 0;
   int errors = 0;
   logic [31:0] if_q[$];
   logic [31:0] ls_q[$];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Monitor: pop expected data whenever a response strobe is seen.
   always @(negedge i_clk) begin
      if (i_rst_n) begin
         chk("one_rvalid", 32'(if_rvalid & ls_rvalid), 32'd0);
         if (if_rvalid) begin
            if (if_q.size() == 0) chk("if_rvalid_unexpected", 32'(if_rvalid), 32'd0);
            else chk("if_rdata", if_rdata, if_q.pop_front());
         end
         if (ls_rvalid) begin
            if (ls_q.size() == 0) chk("ls_rvalid_unexpected", 32'(ls_rvalid), 32'd0);
            else chk("ls_rdata", ls_rdata, ls_q.pop_front());
         end
      end
   end

   // One request cycle: drive, check grants/port at negedge, queue expected response.
   task automatic cyc(input logic ir, input logic [31:0] ia, input logic lr, input logic we,
                      input logic [31:0] la, input logic [2:0] w, input logic [31:0] wd,
                      input logic eig, input logic elg, input logic [31:0] ed,
                      input logic [31:0] ema);
      if_req = ir; if_addr = ia; ls_req = lr; ls_we = we;
      ls_addr = la; ls_width = w; ls_wdata = wd;
      @(negedge i_clk);
      chk("if_gnt", 32'(if_gnt), 32'(eig));
      chk("ls_gnt", 32'(ls_gnt), 32'(elg));
      chk("mem_addr", mem_addr, ema);
      chk("mem_we", 32'(mem_we), 32'(elg & we));
      if (eig) if_q.push_back(ed);
      if (elg) ls_q.push_back(ed);
      @(posedge i_clk); #1;
   endtask

   task automatic idle_cyc();
      if_req = 0; ls_req = 0; ls_we = 0;
      if_addr = 32'h33; ls_addr = 32'h44; ls_wdata = 32'h1234_5678;
      #1;
      chk("idle_gnt", 32'({if_gnt, ls_gnt}), 32'd0);
      chk("idle_addr", mem_addr, 32'd0);
      chk("idle_width", 32'(mem_width), 32'(MEM_W_WORD));
      chk("idle_we", 32'(mem_we), 32'd0);
      chk("idle_wdata", mem_wdata, 32'd0);
      @(posedge i_clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4096; i++) tmem[i] = '0;
      for (int i = 0; i < 3; i++) tmem[i] = 32'hA0 + 32'(i);
      tmem[7] = 32'h0BAD_F00D;

      // Reset with requests pending: nothing may be granted or written.
      if_req = 1; ls_req = 1; ls_we = 1; ls_addr = 32'd6; ls_wdata = 32'h55;
      repeat (2) @(posedge i_clk);
      #1;
      chk("rst_gnt", 32'({if_gnt, ls_gnt}), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_ls_rdata", ls_rdata, 32'd0);
      if_req = 0; ls_req = 0; ls_we = 0;
      i_rst_n = 1;
      @(posedge i_clk); #1;

      idle_cyc();

      // IF-only stream, last address carries upper bits that must be dropped.
      cyc(1, 32'd0,         0, 0, 0, MEM_W_WORD, 0, 1, 0, 32'hA0, 32'd0);
      cyc(1, 32'd1,         0, 0, 0, MEM_W_WORD, 0, 1, 0, 32'hA1, 32'd1);
      cyc(1, 32'h0010_0002, 0, 0, 0, MEM_W_WORD, 0, 1, 0, 32'hA2, 32'd2);

      // Store then loads of varied width (read-after-write back to back).
      cyc(0, 0, 1, 1, 32'd5,         MEM_W_WORD, 32'hDEADBEEF, 0, 1, 32'h0,        32'd5);
      cyc(0, 0, 1, 0, 32'd5,         MEM_W_BYTE, 32'h0,        0, 1, 32'hFFFFFFEF, 32'd5);
      cyc(0, 0, 1, 0, 32'd5,         3'b100,     32'h0,        0, 1, 32'h000000EF, 32'd5);
      cyc(0, 0, 1, 0, 32'd5,         MEM_W_HALF, 32'h0,        0, 1, 32'hFFFFBEEF, 32'd5);
      cyc(0, 0, 1, 0, 32'hABC0_0005, MEM_W_WORD, 32'h0,        0, 1, 32'hDEADBEEF, 32'd5);

      idle_cyc();

      // Contention for 10 cycles: IF wins every 5th.
      for (int k = 1; k <= 10; k++) begin
         if (k % 5 == 0) cyc(1, 32'd1, 1, 0, 32'd5, MEM_W_WORD, 0, 1, 0, 32'hA1, 32'd1);
         else            cyc(1, 32'd1, 1, 0, 32'd5, MEM_W_WORD, 0, 0, 1, 32'hDEADBEEF, 32'd5);
      end
`ifdef MEM_PORT_ARBITER_PERF_EN
      chk("perf_conflict", o_conflict_cnt, 32'd10);
      chk("perf_starve", o_starve_cnt, 32'd2);
`endif

      idle_cyc();

      // Simultaneous request from idle: LS first, then held IF.
      cyc(1, 32'd0, 1, 0, 32'd7, MEM_W_WORD, 0, 0, 1, 32'h0BAD_F00D, 32'd7);
      cyc(1, 32'd0, 0, 0, 32'd7, MEM_W_WORD, 0, 1, 0, 32'hA0,        32'd0);

      idle_cyc();

      // Reset mid-operation: granted load's response is dropped.
      ls_req = 1; ls_we = 0; ls_addr = 32'd5; ls_width = MEM_W_WORD;
      @(negedge i_clk);
      chk("midrst_ls_gnt", 32'(ls_gnt), 32'd1);
      @(posedge i_clk); #1;
      chk("midrst_pre_rvalid", 32'(ls_rvalid), 32'd1);
      chk("midrst_pre_rdata", ls_rdata, 32'hDEADBEEF);
      i_rst_n = 0;
      if_req = 1; ls_we = 1; ls_addr = 32'd6; ls_wdata = 32'h55;
      #1;
      chk("midrst_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd0);
      chk("midrst_ls_rdata", ls_rdata, 32'd0);
      chk("midrst_if_rdata", if_rdata, 32'd0);
      chk("midrst_gnt", 32'({if_gnt, ls_gnt}), 32'd0);
      chk("midrst_we", 32'(mem_we), 32'd0);
      repeat (2) @(posedge i_clk);
      #1;
      chk("midrst_no_store", tmem[6], 32'd0);
      if_req = 0; ls_req = 0; ls_we = 0;
      i_rst_n = 1;
      @(posedge i_clk); #1;

      cyc(1, 32'd2, 0, 0, 0, MEM_W_WORD, 0, 1, 0, 32'hA2, 32'd2);
      idle_cyc();
      idle_cyc();

      chk("if_q_drained", 32'(if_q.size()), 32'd0);
      chk("ls_q_drained", 32'(ls_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
